// File: rtl/jt51_so_pkg.sv
// Shared definitions for the JT51 serial sample transmitter:
// slot boundaries inside a 16-slot channel, FSM encoding and the
// slot-to-bit mapping used to serialise a compressed word.
package jt51_so_pkg;

  // Last slot of each field inside one channel (slots 0..15)
  localparam logic [3:0] MAN_LAST = 4'd9;   // slots 0..9   mantissa, LSB first
  localparam logic [3:0] EXP_LAST = 4'd12;  // slots 10..12 exponent, LSB first
  localparam logic [3:0] CH_LAST  = 4'd15;  // slots 13..15 zero; 15 is the latch slot

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } so_state_t;

  // Compressed word layout is {exp[2:0], man[9:0]}. The mantissa occupies
  // bits 0..MAN_LAST and the exponent the next three bits, so the bit for a
  // given slot is simply that bit of the word, padded with zeros above.
  function automatic logic slot_bit(input logic [12:0] word, input logic [3:0] slot);
    logic [15:0] padded;
    padded = {3'b000, word};
    if (slot <= EXP_LAST) return padded[slot];
    return 1'b0;
  endfunction

endpackage

// File: rtl/jt51_so_float.sv
// Linear 16-bit signed sample to {3-bit exponent, 10-bit mantissa}.
// The exponent is the smallest k in 1..7 for which lin[15:8+k] are all
// equal (pure sign extension); the mantissa is lin[8+k:k-1], truncated.
module jt51_so_float
  import jt51_so_pkg::*;
(
  input  logic [15:0] lin,
  output logic [2:0]  exp,
  output logic [9:0]  man
);

  // eq[j] is set when lin[15:j] are all copies of the sign bit
  logic [15:9] eq;

  // Find the exponent, then take the 10-bit window that starts at bit k-1
  always_comb begin
    eq     = '0;
    eq[15] = 1'b1;
    for (int j = 14; j >= 9; j--) begin
      eq[j] = eq[j+1] & (lin[j] == lin[15]);
    end
    // k=7 always qualifies; scanning downward leaves the smallest match
    exp = 3'd7;
    for (int k = 7; k >= 1; k--) begin
      if (eq[8+k]) exp = 3'(k);
    end
    man = 10'(lin >> (exp - 3'd1));
  end

endmodule

// File: rtl/jt51_so_tx.sv
// Serial sample transmitter for the JT51 output path, YM3012-style.
// Each accepted strobe latches both compressed channels and sends a
// 32-slot frame: left slots 0..15 then right slots 0..15. Outputs are a
// registered view of the current slot, so they trail the FSM by one cen.
module jt51_so_tx
  import jt51_so_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        sample,
  input  logic [15:0] left,
  input  logic [15:0] right,
  output logic        so,
  output logic        sh1,
  output logic        sh2,
  output logic        busy,
  output logic        drop
);

  so_state_t   state, state_nxt;
  logic [3:0]  slot,  slot_nxt;
  logic        load;
  logic        reject;

  logic [2:0]  exp_l, exp_r;
  logic [9:0]  man_l, man_r;
  logic [12:0] word_l, word_r;
  logic [12:0] word_cur;

  logic        so_nxt, sh1_nxt, sh2_nxt, busy_nxt;

  jt51_so_float u_float_l (
    .lin (left),
    .exp (exp_l),
    .man (man_l)
  );

  jt51_so_float u_float_r (
    .lin (right),
    .exp (exp_r),
    .man (man_r)
  );

  // Next-state logic: slot counter, frame sequencing, accept/reject of strobes
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    load      = 1'b0;
    reject    = 1'b0;
    case (state)
      ST_IDLE: begin
        slot_nxt = 4'd0;
        if (sample) begin
          load      = 1'b1;
          state_nxt = ST_LEFT;
        end
      end
      ST_LEFT: begin
        reject = sample;
        if (slot == CH_LAST) begin
          state_nxt = ST_RIGHT;
          slot_nxt  = 4'd0;
        end else begin
          slot_nxt = slot + 4'd1;
        end
      end
      ST_RIGHT: begin
        if (slot == CH_LAST) begin
          // Last slot of the frame is the only point where a new strobe
          // chains straight into the next frame without an idle slot.
          slot_nxt = 4'd0;
          if (sample) begin
            load      = 1'b1;
            state_nxt = ST_LEFT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          reject   = sample;
          slot_nxt = slot + 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        slot_nxt  = 4'd0;
      end
    endcase
  end

  // Output decode for the slot the FSM currently sits in
  always_comb begin
    word_cur = (state == ST_RIGHT) ? word_r : word_l;
    so_nxt   = 1'b0;
    sh1_nxt  = 1'b0;
    sh2_nxt  = 1'b0;
    busy_nxt = 1'b0;
    if (state != ST_IDLE) begin
      so_nxt   = slot_bit(word_cur, slot);
      busy_nxt = 1'b1;
      sh1_nxt  = (state == ST_LEFT)  && (slot == CH_LAST);
      sh2_nxt  = (state == ST_RIGHT) && (slot == CH_LAST);
    end
  end

  // State, holding words and output registers, all advancing only on cen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      slot   <= 4'd0;
      word_l <= '0;
      word_r <= '0;
      so     <= 1'b0;
      sh1    <= 1'b0;
      sh2    <= 1'b0;
      busy   <= 1'b0;
      drop   <= 1'b0;
    end else if (cen) begin
      state <= state_nxt;
      slot  <= slot_nxt;
      if (load) begin
        word_l <= {exp_l, man_l};
        word_r <= {exp_r, man_r};
      end
      so   <= so_nxt;
      sh1  <= sh1_nxt;
      sh2  <= sh2_nxt;
      busy <= busy_nxt;
      drop <= reject;
    end
  end

endmodule

// File: tb/tb_jt51_so_tx.sv
// Bench for jt51_so_tx: table of hand-compressed sample pairs, each sent as
// a frame and checked slot by slot, plus back-to-back, rejected strobe,
// clock-enable hold and mid-frame reset sequences.
module tb_jt51_so_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        sample;
  logic [15:0] left, right;
  logic        so, sh1, sh2, busy, drop;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [2:0]  el;
    logic [9:0]  ml;
    logic [2:0]  er;
    logic [9:0]  mr;
  } vec_t;

  vec_t tv [6];

  jt51_so_tx dut (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .sample (sample),
    .left   (left),
    .right  (right),
    .so     (so),
    .sh1    (sh1),
    .sh2    (sh2),
    .busy   (busy),
    .drop   (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [4:0] exp_v);
    logic [4:0] act;
    act = {so, sh1, sh2, busy, drop};
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s[%0d]: {so,sh1,sh2,busy,drop} got %b expected %b", name, idx, act, exp_v);
    end
  endtask

  // Expected {so,sh1,sh2,busy} for frame slot i (0..31)
  function automatic logic [3:0] slot_exp(input vec_t v, input int i);
    logic [2:0] e;
    logic [9:0] m;
    int s;
    logic b;
    s = i % 16;
    e = (i < 16) ? v.el : v.er;
    m = (i < 16) ? v.ml : v.mr;
    if (s <= 9)       b = m[s];
    else if (s <= 12) b = e[s-10];
    else              b = 1'b0;
    return {b, (i == 15), (i == 31), 1'b1};
  endfunction

  // Strobe one sample pair from idle; outputs must still be idle after the edge
  task automatic strobe(input vec_t v, input string name);
    cen = 1'b1; sample = 1'b1; left = v.l; right = v.r;
    @(posedge clk); #1;
    sample = 1'b0; left = 16'($urandom); right = 16'($urandom);
    chk({name, "_lat"}, 0, 5'b00000);
  endtask

  // Walk one frame. Optional: restart with nv at the last slot, extra strobe
  // at drop_slot, cen hold after hold_slot, reset after rst_slot.
  task automatic frame(input vec_t v, input string name, input logic restart,
                       input vec_t nv, input int drop_slot, input int hold_slot,
                       input int rst_slot);
    logic [4:0] e;
    for (int i = 0; i < 32; i++) begin
      cen = 1'b1;
      if (restart && i == 31) begin
        sample = 1'b1; left = nv.l; right = nv.r;
      end else if (i == drop_slot) begin
        sample = 1'b1; left = 16'($urandom); right = 16'($urandom);
      end
      @(posedge clk); #1;
      sample = 1'b0; left = 16'($urandom); right = 16'($urandom);
      e = {slot_exp(v, i), (i == drop_slot)};
      chk(name, i, e);
      if (i == hold_slot) begin
        cen = 1'b0; sample = 1'b1;
        for (int h = 0; h < 10; h++) begin
          @(posedge clk); #1;
          chk({name, "_hold"}, h, e);
        end
        sample = 1'b0; cen = 1'b1;
      end
      if (i == rst_slot) begin
        #3 rst = 1'b1;
        #1 chk({name, "_rst_async"}, i, 5'b00000);
        @(posedge clk); #1;
        chk({name, "_rst_held"}, i, 5'b00000);
        rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic tail(input string name);
    cen = 1'b1; sample = 1'b0;
    @(posedge clk); #1;
    chk({name, "_idle"}, 0, 5'b00000);
  endtask

  initial begin
    vec_t none;
    tv[0] = '{16'h0001, 16'h0000, 3'd1, 10'h001, 3'd1, 10'h000};
    tv[1] = '{16'h7FFF, 16'h8000, 3'd7, 10'h1FF, 3'd7, 10'h200};
    tv[2] = '{16'h0400, 16'hFE00, 3'd3, 10'h100, 3'd1, 10'h200};
    tv[3] = '{16'hFFFF, 16'h0100, 3'd1, 10'h3FF, 3'd1, 10'h100};
    tv[4] = '{16'h1234, 16'hC000, 3'd5, 10'h123, 3'd6, 10'h200};
    tv[5] = '{16'h8001, 16'h00FF, 3'd7, 10'h200, 3'd1, 10'h0FF};
    none  = tv[0];

    rst = 1'b1; cen = 1'b0; sample = 1'b0; left = '0; right = '0;
    #1 chk("reset", 0, 5'b00000);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cen = 1'b1;
    @(posedge clk); #1;
    chk("reset_idle", 0, 5'b00000);

    // Each table entry as an isolated frame
    for (int k = 0; k < 6; k++) begin
      strobe(tv[k], $sformatf("vec%0d", k));
      frame(tv[k], $sformatf("vec%0d", k), 1'b0, none, -1, -1, -1);
      tail($sformatf("vec%0d", k));
    end

    // Seamless back-to-back frames: busy stays high, no drop
    strobe(tv[0], "b2b");
    frame(tv[0], "b2b_f0", 1'b1, tv[1], -1, -1, -1);
    frame(tv[1], "b2b_f1", 1'b1, tv[2], -1, -1, -1);
    frame(tv[2], "b2b_f2", 1'b0, none, -1, -1, -1);
    tail("b2b");

    // Extra strobes mid-frame are rejected and leave the frame intact
    strobe(tv[3], "rej");
    frame(tv[3], "rej_l5", 1'b0, none, 5, -1, -1);
    tail("rej_l5");
    strobe(tv[4], "rej2");
    frame(tv[4], "rej_r14", 1'b0, none, 30, -1, -1);
    tail("rej_r14");

    // cen low for 10 clocks mid-frame freezes everything, including sample
    strobe(tv[4], "hold");
    frame(tv[4], "hold", 1'b0, none, -1, 20, -1);
    tail("hold");

    // Async reset at right slot 7, then a clean frame
    strobe(tv[5], "rst");
    frame(tv[5], "rst", 1'b0, none, -1, -1, 23);
    tail("rst_after");
    strobe(tv[1], "post_rst");
    frame(tv[1], "post_rst", 1'b0, none, -1, -1, -1);
    tail("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jt51_so_tx.md
# jt51_so_tx

Serial sample transmitter for the JT51 output path. It takes the exact 16-bit signed left/right samples produced once per sample period and compresses each to a 10-bit mantissa plus 3-bit exponent. It then shifts them out on a single serial data line with two channel-latch strobes, in the style of a YM3012-type external DAC. It sits after the accumulator and is the transmitting end of the chip-to-DAC serial link.

## Interface
Parameters: none.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `cen`  in  1  clock enable; every state change is qualified by `cen`
- `sample`  in  1  new-sample strobe, valid only when `cen`=1
- `left`  in  16  signed left sample, sampled with `sample`
- `right`  in  16  signed right sample, sampled with `sample`
- `so`  out  1  serial data, one bit slot per `cen`
- `sh1`  out  1  left latch strobe
- `sh2`  out  1  right latch strobe
- `busy`  out  1  frame in progress
- `drop`  out  1  one-`cen` pulse: strobe rejected

## Operation
- Compression, per channel, combinational:
  - Exponent k (1..7) is the smallest value with `lin[15:8+k]` all equal.
  - Mantissa = `lin[8+k:k-1]`, 10 bits, truncated, sign preserved.
  - k=7 always qualifies.
- Frame structure:
  - A frame is 32 slots: left channel in slots 0–15, then right channel in slots 0–15.
  - Within each channel: slots 0–9 carry the mantissa, LSB first.
  - Slots 10–12 carry the exponent, LSB first.
  - Slots 13–15 carry 0.
- Latch strobes:
  - `sh1`=1 only during left slot 15.
  - `sh2`=1 only during right slot 15.
  - The DAC latches on the strobe's falling edge.
- FSM states:
  - IDLE: `so`=0, `busy`=0. On `sample`&`cen`, latch the compressed left/right words and go to LEFT with slot=0.
  - LEFT: slot increments every `cen`. At slot 15 go to RIGHT with slot=0.
  - RIGHT: slot increments every `cen`. At slot 15: if `sample`&`cen`, latch new words and go to LEFT with slot=0 (seamless, no gap). Otherwise go to IDLE.
- Strobe while busy at any point other than RIGHT slot 15:
  - The sample is discarded and the frame in flight is unchanged.
  - `drop`=1 for exactly one `cen` period.
- Words are latched at strobe time. Changing `left`/`right` mid-frame has no effect.

## Timing
- Reset: `so`=0, `sh1`=0, `sh2`=0, `busy`=0, `drop`=0, state IDLE, slot=0. Effective immediately and asynchronously, including mid-frame.
- Outputs are registered and update only on `clk` edges with `cen`=1.
- `so`, `sh1`, `sh2` and `busy` reflect the current slot. Latency: left slot 0 appears at the first `cen` edge after the strobe edge.
- `busy` rises with left slot 0 and falls after right slot 15 unless a seamless restart occurs.
- A full frame lasts 32 `cen` periods. The minimum sample spacing for loss-free operation is 32 `cen` periods.
- `drop` clears on the next `cen` edge.
- `cen` low: all outputs hold their value.

## Structure
- Shared package `jt51_so_pkg`:
  - Slot constants: `MAN_LAST`=9, `EXP_LAST`=12, `CH_LAST`=15.
  - FSM state encoding: IDLE, LEFT, RIGHT.
- Sub-module `jt51_so_float`: combinational 16-bit linear to {3-bit exp, 10-bit mantissa} compressor, instantiated twice.
- Top module: FSM, 4-bit slot counter, two 13-bit holding registers, output registers.

## Test plan
- Small positive value:
  - Stimulus: `left`=16'h0001, `right`=16'h0000, single strobe.
  - Left word: exp 1, man 10'h001. `so` over left slots 0–15 = 1,0×9,1,0,0,0,0,0; `sh1` high only at slot 15.
  - Right word: exp 1, man 0.
  - `busy` low after 32 `cen` periods.
- Full scale:
  - Stimulus: `left`=16'h7FFF, `right`=16'h8000.
  - Left: exp 7, man 10'h1FF. Right: exp 7, man 10'h200.
  - Check that exactly 3 bits exp, then 3 zeros, follow each mantissa.
- Middle exponent:
  - Stimulus: `left`=16'h0400, `right`=16'hFE00.
  - Left: exp 3, man 10'h100. Right: exp 1, man 10'h200.
- Back-to-back and rejected strobes:
  - Strobes 32 `cen` apart: two frames sent with no idle slot; `busy` stays high; `drop` never pulses.
  - Extra strobe at left slot 5: `drop` pulses once; frame content unchanged.
- Reset and clock enable:
  - Assert `rst` at right slot 7: all outputs go to 0 immediately.
  - After release, the next strobe starts a clean frame at left slot 0.
  - Hold `cen`=0 for 10 clocks mid-frame: outputs frozen; frame resumes intact.
